// File: rtl/md5_pkg.sv
// Shared MD5 constants, step-schedule helpers and types for the iterative MD5 core.
package md5_pkg;

   localparam logic [31:0] IV_A = 32'h67452301;
   localparam logic [31:0] IV_B = 32'hefcdab89;
   localparam logic [31:0] IV_C = 32'h98badcfe;
   localparam logic [31:0] IV_D = 32'h10325476;

   localparam logic [31:0] K [0:63] = '{
      32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
      32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
      32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
      32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
      32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
      32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
      32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
      32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
      32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
      32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
      32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
      32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
      32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
      32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
      32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
      32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
   };

   localparam logic [4:0] S [0:63] = '{
      5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
      5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
      5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
      5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
      5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
      5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
      5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21,
      5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21
   };

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD} md5_state_e;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [31:0] d;
   } md5_abcd_t;

   function automatic logic [31:0] k_of(input logic [5:0] i);
      return K[i];
   endfunction

   function automatic logic [4:0] s_of(input logic [5:0] i);
      return S[i];
   endfunction

   // Message-word schedule; 4-bit arithmetic gives the mod-16 for free.
   function automatic logic [3:0] g_of(input logic [5:0] i);
      logic [3:0] l;
      l = i[3:0];
      case (i[5:4])
         2'd0:    return l;
         2'd1:    return 4'(l * 4'd5 + 4'd1);
         2'd2:    return 4'(l * 4'd3 + 4'd5);
         default: return 4'(l * 4'd7);
      endcase
   endfunction

   function automatic logic [31:0] swap32(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

   function automatic bit unroll_legal(input int u);
      return (u == 1) || (u == 2) || (u == 4) || (u == 8) || (u == 16);
   endfunction

endpackage

// File: rtl/md5_step.sv
// One combinational MD5 step; the step index is a runtime input so copies can be chained.
module md5_step
   import md5_pkg::*;
(
   input  logic [5:0]   idx,
   input  logic [511:0] m,
   input  md5_abcd_t    st_i,
   output md5_abcd_t    st_o
);

   logic [31:0] f, w, sum, rot;
   logic [3:0]  g;
   logic [4:0]  s;

   always_comb begin
      f = '0;
      w = '0;
      case (idx[5:4])
         2'd0:    f = (st_i.b & st_i.c) | (~st_i.b & st_i.d);
         2'd1:    f = (st_i.d & st_i.b) | (~st_i.d & st_i.c);
         2'd2:    f = st_i.b ^ st_i.c ^ st_i.d;
         default: f = st_i.c ^ (st_i.b | ~st_i.d);
      endcase
      g = g_of(idx);
      // Block bytes are big-end-first on the bus; MD5 words are little-endian.
      for (int k = 0; k < 16; k++)
         if (g == 4'(k)) w = swap32(m[511-32*k -: 32]);
      sum = st_i.a + f + k_of(idx) + w;
      s   = s_of(idx);
      rot = (sum << s) | (sum >> (6'd32 - {1'b0, s}));
      st_o.a = st_i.d;
      st_o.b = st_i.b + rot;
      st_o.c = st_i.b;
      st_o.d = st_i.c;
   end

endmodule

// File: rtl/md5_iter_core.sv
// Area-folded MD5 compression core: UNROLL chained steps per clock, valid/ready on both sides,
// pass-through tag and optional compare against a target digest.
module md5_iter_core
   import md5_pkg::*;
#(
   parameter int unsigned UNROLL     = 4,
   parameter bit          COMPARE_EN = 1'b1,
   parameter int unsigned TAG_W      = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [511:0]     m_in,
   input  logic [TAG_W-1:0] tag_in,
   input  logic [127:0]     target,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     digest,
   output logic [TAG_W-1:0] tag_out,
   output logic             match
);

   if (!unroll_legal(UNROLL)) begin : g_bad_unroll
      $error("md5_iter_core: UNROLL must be 1, 2, 4, 8 or 16");
   end

   md5_state_e state_q, state_d;
   logic [5:0]       step_q;
   logic [511:0]     msg_q;
   logic [TAG_W-1:0] tag_q;
   logic [127:0]     target_q;
   md5_abcd_t        abcd_q;
   md5_abcd_t [UNROLL:0] chain;
   logic             accept, last;
   logic [127:0]     digest_n;
   logic             match_n;

   assign in_ready = en && (state_q == ST_IDLE || (state_q == ST_HOLD && out_ready));
   assign accept   = in_valid && in_ready;
   assign last     = (step_q == 6'(64 - UNROLL));

   assign chain[0] = abcd_q;
   for (genvar j = 0; j < UNROLL; j++) begin : g_step
      md5_step u_step (
         .idx  (step_q + 6'(j)),
         .m    (msg_q),
         .st_i (chain[j]),
         .st_o (chain[j+1])
      );
   end

   assign digest_n = {swap32(chain[UNROLL].a + IV_A), swap32(chain[UNROLL].b + IV_B),
                      swap32(chain[UNROLL].c + IV_C), swap32(chain[UNROLL].d + IV_D)};
   assign match_n  = COMPARE_EN && (digest_n == target_q);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = ST_RUN;
         ST_RUN:  if (en && last) state_d = ST_HOLD;
         ST_HOLD: if (en && out_ready) state_d = in_valid ? ST_RUN : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         step_q    <= '0;
         msg_q     <= '0;
         tag_q     <= '0;
         target_q  <= '0;
         abcd_q    <= '0;
         out_valid <= 1'b0;
         digest    <= '0;
         tag_out   <= '0;
         match     <= 1'b0;
      end else if (en) begin
         // HOLD exit first; a same-edge accept below does not touch out_valid.
         if (state_q == ST_HOLD && out_ready) out_valid <= 1'b0;
         if (accept) begin
            abcd_q   <= '{a: IV_A, b: IV_B, c: IV_C, d: IV_D};
            step_q   <= '0;
            msg_q    <= m_in;
            tag_q    <= tag_in;
            target_q <= target;
         end else if (state_q == ST_RUN) begin
            abcd_q <= chain[UNROLL];
            step_q <= step_q + 6'(UNROLL);
            if (last) begin
               digest    <= digest_n;
               tag_out   <= tag_q;
               match     <= match_n;
               out_valid <= 1'b1;
            end
         end
      end
   end

endmodule
